// File: rtl/game_supervisor_pkg.sv
// Shared types for the game supervisor: status encodings and a small popcount helper.
package game_supervisor_pkg;

    localparam int unsigned GAME_STATUS_BIT_LEN = 3;
    localparam int unsigned POP_IN_W            = 16;
    localparam int unsigned POP_OUT_W           = 5;

    typedef enum logic [GAME_STATUS_BIT_LEN-1:0] {
        GAME_STATUS_PAUSE  = 3'b000,
        GAME_STATUS_RUN    = 3'b001,
        GAME_STATUS_PRERUN = 3'b010,
        GAME_STATUS_OVER   = 3'b011
    } game_status_e;

    // Number of set bits in a zero-extended hit vector.
    function automatic logic [POP_OUT_W-1:0] popcount16(input logic [POP_IN_W-1:0] v);
        logic [POP_OUT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < POP_IN_W; i++) begin
            c = c + POP_OUT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/crash_accum.sv
// Sticky OR-accumulator of per-pixel collisions; publishes the frame result on commit.
module crash_accum #(
    parameter int unsigned W = 1
) (
    input  logic         clk_vga,
    input  logic         rst_n,
    input  logic         acc_en,
    input  logic         clear,
    input  logic         commit,
    input  logic [W-1:0] hit,
    output logic [W-1:0] acc,
    output logic [W-1:0] crash
);

    // The commit-cycle pixel is dropped: acc restarts from zero on commit.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            crash <= '0;
        end else begin
            if (!acc_en || commit) acc <= '0;
            else                   acc <= acc | hit;
            if (clear)             crash <= '0;
            else if (commit)       crash <= acc;
        end
    end

endmodule

// File: rtl/game_supervisor.sv
// Game state machine with per-frame collision commit, lives, invulnerability, bombs and score.
module game_supervisor
    import game_supervisor_pkg::*;
#(
    parameter int unsigned N_ENEMY       = 4,
    parameter int unsigned LIVES_W       = 3,
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned BOMB_W        = 2,
    parameter int unsigned INIT_BOMBS    = 1,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned INVULN_W      = 7,
    parameter int unsigned SCORE_W       = 16
) (
    input  logic                           clk_vga,
    input  logic                           rst_n,
    input  logic                           frame_start_i,
    input  logic                           disp_i,
    input  logic                           me_alpha_i,
    input  logic                           bullet_alpha_i,
    input  logic [N_ENEMY-1:0]             enemy_alpha_i,
    input  logic                           bonus_alpha_i,
    input  logic                           start_i,
    input  logic                           pause_i,
    input  logic                           bomb_req_i,
    output logic [GAME_STATUS_BIT_LEN-1:0] game_status_o,
    output logic [N_ENEMY-1:0]             crash_me_enemy_o,
    output logic [N_ENEMY-1:0]             crash_enemy_bullet_o,
    output logic                           crash_me_bonus_o,
    output logic                           hit_valid_o,
    output logic                           bomb_o,
    output logic [LIVES_W-1:0]             lives_o,
    output logic [BOMB_W-1:0]              bombs_o,
    output logic [SCORE_W-1:0]             score_o,
    output logic                           invuln_o
);

    localparam int unsigned SUM_W = SCORE_W + 1;
    localparam logic [BOMB_W-1:0]  BOMB_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_status_e         state, state_d;
    logic [LIVES_W-1:0]   lives, lives_d;
    logic [BOMB_W-1:0]    bombs, bombs_d;
    logic [SCORE_W-1:0]   score, score_d;
    logic [INVULN_W-1:0]  invuln, invuln_d;
    logic                 hit_valid_d, bomb_d;

    logic                 run, commit, clear_crash;
    logic [N_ENEMY-1:0]   me_enemy_px, bullet_enemy_px;
    logic                 me_bonus_px;
    logic [N_ENEMY-1:0]   acc_me, acc_bullet;
    logic                 acc_bonus;
    logic [SUM_W-1:0]     score_sum;

    assign run         = (state == GAME_STATUS_RUN);
    assign commit      = run && frame_start_i;
    assign clear_crash = start_i && ((state == GAME_STATUS_PRERUN) || (state == GAME_STATUS_OVER));

    assign me_enemy_px     = {N_ENEMY{disp_i & me_alpha_i}} & enemy_alpha_i;
    assign bullet_enemy_px = {N_ENEMY{disp_i & bullet_alpha_i}} & enemy_alpha_i;
    assign me_bonus_px     = disp_i & me_alpha_i & bonus_alpha_i;

    crash_accum #(.W(N_ENEMY)) u_acc_me_enemy (
        .clk_vga(clk_vga), .rst_n(rst_n), .acc_en(run), .clear(clear_crash), .commit(commit),
        .hit(me_enemy_px), .acc(acc_me), .crash(crash_me_enemy_o)
    );

    crash_accum #(.W(N_ENEMY)) u_acc_enemy_bullet (
        .clk_vga(clk_vga), .rst_n(rst_n), .acc_en(run), .clear(clear_crash), .commit(commit),
        .hit(bullet_enemy_px), .acc(acc_bullet), .crash(crash_enemy_bullet_o)
    );

    crash_accum #(.W(1)) u_acc_me_bonus (
        .clk_vga(clk_vga), .rst_n(rst_n), .acc_en(run), .clear(clear_crash), .commit(commit),
        .hit(me_bonus_px), .acc(acc_bonus), .crash(crash_me_bonus_o)
    );

    assign score_sum = SUM_W'(score) + SUM_W'(popcount16(POP_IN_W'(acc_bullet)));

    // Next-state: bomb spend is applied before the bonus refill so saturation nets out.
    always_comb begin
        state_d     = state;
        lives_d     = lives;
        bombs_d     = bombs;
        score_d     = score;
        invuln_d    = invuln;
        hit_valid_d = 1'b0;
        bomb_d      = 1'b0;
        case (state)
            GAME_STATUS_PRERUN, GAME_STATUS_OVER: begin
                if (start_i) begin
                    state_d  = GAME_STATUS_RUN;
                    lives_d  = LIVES_W'(INIT_LIVES);
                    bombs_d  = BOMB_W'(INIT_BOMBS);
                    score_d  = '0;
                    invuln_d = '0;
                end
            end
            GAME_STATUS_RUN: begin
                if (bomb_req_i && (bombs != '0)) begin
                    bombs_d = bombs - BOMB_W'(1);
                    bomb_d  = 1'b1;
                end
                if (commit) begin
                    hit_valid_d = 1'b1;
                    score_d     = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
                    if (acc_bonus && (bombs_d != BOMB_MAX)) bombs_d = bombs_d + BOMB_W'(1);
                    if ((|acc_me) && (invuln == '0)) begin
                        if (lives == LIVES_W'(1)) begin
                            lives_d = '0;
                            state_d = GAME_STATUS_OVER;
                        end else begin
                            lives_d  = lives - LIVES_W'(1);
                            invuln_d = INVULN_W'(INVULN_FRAMES);
                        end
                    end else if (invuln != '0) begin
                        invuln_d = invuln - INVULN_W'(1);
                    end
                end
                if (pause_i && (state_d == GAME_STATUS_RUN)) state_d = GAME_STATUS_PAUSE;
            end
            GAME_STATUS_PAUSE: begin
                if (pause_i) state_d = GAME_STATUS_RUN;
            end
            default: state_d = GAME_STATUS_PRERUN;
        endcase
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state       <= GAME_STATUS_PRERUN;
            lives       <= LIVES_W'(INIT_LIVES);
            bombs       <= BOMB_W'(INIT_BOMBS);
            score       <= '0;
            invuln      <= '0;
            invuln_o    <= 1'b0;
            hit_valid_o <= 1'b0;
            bomb_o      <= 1'b0;
        end else begin
            state       <= state_d;
            lives       <= lives_d;
            bombs       <= bombs_d;
            score       <= score_d;
            invuln      <= invuln_d;
            invuln_o    <= (invuln_d != '0);
            hit_valid_o <= hit_valid_d;
            bomb_o      <= bomb_d;
        end
    end

    assign game_status_o = state;
    assign lives_o       = lives;
    assign bombs_o       = bombs;
    assign score_o       = score;

endmodule

// File: tb/tb_game_supervisor.sv
// Directed and randomized checks of game_supervisor against a frame-level behavioural model.
module tb_game_supervisor;

    localparam int N = 4;
    localparam int ST_PAUSE = 0, ST_RUN = 1, ST_PRERUN = 2, ST_OVER = 3;
    localparam logic [35:0] RESET_VEC = {3'b010, 3'd3, 2'd1, 16'd0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0};

    logic         clk_vga = 1'b0;
    logic         rst_n;
    logic         frame_start_i, disp_i, me_alpha_i, bullet_alpha_i, bonus_alpha_i;
    logic [N-1:0] enemy_alpha_i;
    logic         start_i, pause_i, bomb_req_i;
    logic [2:0]   game_status_o;
    logic [N-1:0] crash_me_enemy_o, crash_enemy_bullet_o;
    logic         crash_me_bonus_o, hit_valid_o, bomb_o, invuln_o;
    logic [2:0]   lives_o;
    logic [1:0]   bombs_o;
    logic [15:0]  score_o;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: collisions counted per frame, outcomes applied on the commit.
    int           m_st, m_lives, m_bombs, m_score, m_inv;
    int           m_cnt_me[N], m_cnt_bul[N], m_cnt_bonus;
    logic [N-1:0] m_crash_me, m_crash_bul;
    logic         m_crash_bonus, m_hv, m_bomb;

    logic [35:0] obs;
    assign obs = {game_status_o, lives_o, bombs_o, score_o, invuln_o, hit_valid_o, bomb_o,
                  crash_me_enemy_o, crash_enemy_bullet_o, crash_me_bonus_o};

    always #5 clk_vga = ~clk_vga;

    game_supervisor dut (
        .clk_vga(clk_vga), .rst_n(rst_n), .frame_start_i(frame_start_i), .disp_i(disp_i),
        .me_alpha_i(me_alpha_i), .bullet_alpha_i(bullet_alpha_i), .enemy_alpha_i(enemy_alpha_i),
        .bonus_alpha_i(bonus_alpha_i), .start_i(start_i), .pause_i(pause_i), .bomb_req_i(bomb_req_i),
        .game_status_o(game_status_o), .crash_me_enemy_o(crash_me_enemy_o),
        .crash_enemy_bullet_o(crash_enemy_bullet_o), .crash_me_bonus_o(crash_me_bonus_o),
        .hit_valid_o(hit_valid_o), .bomb_o(bomb_o), .lives_o(lives_o), .bombs_o(bombs_o),
        .score_o(score_o), .invuln_o(invuln_o)
    );

    function automatic logic [35:0] model_vec();
        return {3'(m_st), 3'(m_lives), 2'(m_bombs), 16'(m_score), (m_inv != 0), m_hv, m_bomb,
                m_crash_me, m_crash_bul, m_crash_bonus};
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            m_cnt_me[i]  = 0;
            m_cnt_bul[i] = 0;
        end
        m_cnt_bonus = 0;
    endtask

    task automatic model_reset();
        m_st = ST_PRERUN; m_lives = 3; m_bombs = 1; m_score = 0; m_inv = 0;
        m_crash_me = '0; m_crash_bul = '0; m_crash_bonus = 1'b0; m_hv = 1'b0; m_bomb = 1'b0;
        clear_counts();
    endtask

    task automatic model_step();
        int nb, hits;
        bit any_me;
        m_hv = 1'b0;
        m_bomb = 1'b0;
        case (m_st)
            ST_PRERUN, ST_OVER: begin
                if (start_i) begin
                    m_st = ST_RUN; m_lives = 3; m_bombs = 1; m_score = 0; m_inv = 0;
                    m_crash_me = '0; m_crash_bul = '0; m_crash_bonus = 1'b0;
                end
            end
            ST_RUN: begin
                nb = m_bombs;
                if (bomb_req_i && m_bombs > 0) begin
                    m_bomb = 1'b1;
                    nb--;
                end
                if (frame_start_i) begin
                    m_hv = 1'b1; hits = 0; any_me = 0;
                    for (int i = 0; i < N; i++) begin
                        m_crash_me[i]  = (m_cnt_me[i] > 0);
                        m_crash_bul[i] = (m_cnt_bul[i] > 0);
                        if (m_cnt_bul[i] > 0) hits++;
                        if (m_cnt_me[i] > 0) any_me = 1;
                    end
                    m_crash_bonus = (m_cnt_bonus > 0);
                    m_score = (m_score + hits > 65535) ? 65535 : m_score + hits;
                    if (m_cnt_bonus > 0 && nb < 3) nb++;
                    if (any_me && m_inv == 0) begin
                        if (m_lives == 1) begin
                            m_lives = 0;
                            m_st = ST_OVER;
                        end else begin
                            m_lives--;
                            m_inv = 120;
                        end
                    end else if (m_inv > 0) begin
                        m_inv--;
                    end
                    clear_counts();
                end else if (disp_i) begin
                    for (int i = 0; i < N; i++) begin
                        if (me_alpha_i && enemy_alpha_i[i]) m_cnt_me[i]++;
                        if (bullet_alpha_i && enemy_alpha_i[i]) m_cnt_bul[i]++;
                    end
                    if (me_alpha_i && bonus_alpha_i) m_cnt_bonus++;
                end
                m_bombs = nb;
                if (pause_i && m_st == ST_RUN) m_st = ST_PAUSE;
            end
            ST_PAUSE: if (pause_i) m_st = ST_RUN;
            default: m_st = ST_PRERUN;
        endcase
        if (m_st != ST_RUN) clear_counts();
    endtask

    // One clock: model advances on the inputs present, pulses drop afterwards.
    task automatic tick();
        model_step();
        @(posedge clk_vga);
        #1;
        start_i = 1'b0; pause_i = 1'b0; bomb_req_i = 1'b0; frame_start_i = 1'b0;
    endtask

    task automatic set_px(input logic d, input logic me, input logic bul,
                          input logic [N-1:0] en, input logic bon);
        disp_i = d; me_alpha_i = me; bullet_alpha_i = bul; enemy_alpha_i = en; bonus_alpha_i = bon;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_vga);
        #1;
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_state got %h exp %h", obs, RESET_VEC);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_idle got %h exp %h", obs, model_vec());
        end
    endtask

    task automatic test_start();
        start_i = 1'b1;
        tick();
        vectors++;
        if (game_status_o !== 3'b001 || lives_o !== 3'd3 || bombs_o !== 2'd1 || score_o !== 16'd0) begin
            miscompares++;
            $display("FAIL start status=%b lives=%0d bombs=%0d score=%0d exp 001/3/1/0",
                     game_status_o, lives_o, bombs_o, score_o);
        end
    endtask

    task automatic test_bullet_hits();
        set_px(1, 0, 1, 4'b0100, 0);
        repeat (5) tick();
        set_px(0, 0, 0, 4'b0000, 0);
        tick();
        frame_start_i = 1'b1;
        tick();
        vectors++;
        if (crash_enemy_bullet_o !== 4'b0100 || hit_valid_o !== 1'b1 || score_o !== 16'd1) begin
            miscompares++;
            $display("FAIL bullet_commit bullet=%b hv=%b score=%0d exp 0100/1/1",
                     crash_enemy_bullet_o, hit_valid_o, score_o);
        end
        tick();
        vectors++;
        if (hit_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_valid_pulse got %b exp 0", hit_valid_o);
        end
        set_px(0, 0, 1, 4'b0100, 0);
        repeat (5) tick();
        set_px(0, 0, 0, 4'b0000, 0);
        frame_start_i = 1'b1;
        tick();
        vectors++;
        if (crash_enemy_bullet_o !== 4'b0000 || score_o !== 16'd1 || obs !== model_vec()) begin
            miscompares++;
            $display("FAIL bullet_nodisp got %h exp %h", obs, model_vec());
        end
    endtask

    task automatic test_invuln();
        for (int f = 0; f < 3; f++) begin
            set_px(1, 1, 0, 4'b0001, 0);
            tick();
            set_px(0, 0, 0, 4'b0000, 0);
            frame_start_i = 1'b1;
            tick();
            vectors++;
            if (lives_o !== 3'd2 || invuln_o !== 1'b1 || crash_me_enemy_o !== 4'b0001) begin
                miscompares++;
                $display("FAIL invuln_frame%0d lives=%0d inv=%b me=%b exp 2/1/0001",
                         f, lives_o, invuln_o, crash_me_enemy_o);
            end
        end
        for (int k = 3; k <= 120; k++) begin
            frame_start_i = 1'b1;
            tick();
            if (k == 119 || k == 120) begin
                vectors++;
                if (invuln_o !== (k == 119) || obs !== model_vec()) begin
                    miscompares++;
                    $display("FAIL invuln_expire_%0d got %h exp %h", k, obs, model_vec());
                end
            end
        end
        set_px(1, 1, 0, 4'b0001, 0);
        tick();
        set_px(0, 0, 0, 4'b0000, 0);
        frame_start_i = 1'b1;
        tick();
        vectors++;
        if (lives_o !== 3'd1 || invuln_o !== 1'b1) begin
            miscompares++;
            $display("FAIL invuln_rehit lives=%0d inv=%b exp 1/1", lives_o, invuln_o);
        end
    endtask

    task automatic test_over_pause();
        repeat (120) begin
            frame_start_i = 1'b1;
            tick();
        end
        vectors++;
        if (invuln_o !== 1'b0) begin
            miscompares++;
            $display("FAIL over_inv_clear got %b exp 0", invuln_o);
        end
        set_px(1, 1, 0, 4'b0001, 0);
        tick();
        set_px(0, 0, 0, 4'b0000, 0);
        frame_start_i = 1'b1;
        pause_i = 1'b1;
        tick();
        vectors++;
        if (game_status_o !== 3'b011 || lives_o !== 3'd0) begin
            miscompares++;
            $display("FAIL over_wins status=%b lives=%0d exp 011/0", game_status_o, lives_o);
        end
        pause_i = 1'b1;
        tick();
        start_i = 1'b1;
        tick();
        vectors++;
        if (game_status_o !== 3'b001 || lives_o !== 3'd3 || crash_me_enemy_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL restart status=%b lives=%0d me=%b exp 001/3/0000",
                     game_status_o, lives_o, crash_me_enemy_o);
        end
    endtask

    task automatic test_bomb();
        bomb_req_i = 1'b1;
        tick();
        vectors++;
        if (bomb_o !== 1'b1 || bombs_o !== 2'd0) begin
            miscompares++;
            $display("FAIL bomb_fire bomb=%b bombs=%0d exp 1/0", bomb_o, bombs_o);
        end
        set_px(1, 1, 0, 4'b0000, 1);
        tick();
        set_px(0, 0, 0, 4'b0000, 0);
        frame_start_i = 1'b1;
        bomb_req_i = 1'b1;
        tick();
        vectors++;
        if (bomb_o !== 1'b0 || bombs_o !== 2'd1 || crash_me_bonus_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bomb_empty_bonus bomb=%b bombs=%0d bonus=%b exp 0/1/1",
                     bomb_o, bombs_o, crash_me_bonus_o);
        end
        bomb_req_i = 1'b1;
        tick();
        vectors++;
        if (bomb_o !== 1'b1 || bombs_o !== 2'd0) begin
            miscompares++;
            $display("FAIL bomb_refire bomb=%b bombs=%0d exp 1/0", bomb_o, bombs_o);
        end
        for (int f = 0; f < 4; f++) begin
            set_px(1, 1, 0, 4'b0000, 1);
            tick();
            set_px(0, 0, 0, 4'b0000, 0);
            frame_start_i = 1'b1;
            bomb_req_i = (f == 3);
            tick();
        end
        vectors++;
        if (bomb_o !== 1'b1 || bombs_o !== 2'd3) begin
            miscompares++;
            $display("FAIL bomb_saturated bomb=%b bombs=%0d exp 1/3", bomb_o, bombs_o);
        end
    endtask

    task automatic test_pause_freeze();
        logic [35:0] snap;
        set_px(1, 1, 1, 4'b1010, 0);
        tick();
        set_px(0, 0, 0, 4'b0000, 0);
        frame_start_i = 1'b1;
        tick();
        vectors++;
        if (obs !== model_vec() || crash_me_enemy_o !== 4'b1010 || invuln_o !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_setup got %h exp %h", obs, model_vec());
        end
        pause_i = 1'b1;
        tick();
        snap = obs;
        set_px(1, 1, 1, 4'b1111, 1);
        for (int f = 0; f < 10; f++) begin
            repeat (3) tick();
            frame_start_i = 1'b1;
            tick();
            vectors++;
            if (obs !== snap || game_status_o !== 3'b000) begin
                miscompares++;
                $display("FAIL pause_frozen_%0d got %h exp %h", f, obs, snap);
            end
        end
        pause_i = 1'b1;
        tick();
        frame_start_i = 1'b1;
        tick();
        vectors++;
        if (hit_valid_o !== 1'b1 || crash_me_enemy_o !== 4'b0 || crash_enemy_bullet_o !== 4'b0
            || crash_me_bonus_o !== 1'b0 || obs !== model_vec()) begin
            miscompares++;
            $display("FAIL pause_resume_empty got %h exp %h", obs, model_vec());
        end
        set_px(0, 0, 0, 4'b0000, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 6000; c++) begin
            set_px(($urandom % 4) != 0, $urandom % 2, $urandom % 2, 4'($urandom), ($urandom % 4) == 0);
            frame_start_i = ($urandom % 8) == 0;
            pause_i       = ($urandom % 90) == 0;
            start_i       = ($urandom % 50) == 0;
            bomb_req_i    = ($urandom % 10) == 0;
            tick();
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL random_cycle_%0d got %h exp %h", c, obs, model_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        start_i = 1'b1;
        tick();
        set_px(1, 1, 1, 4'b1111, 1);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (obs !== RESET_VEC) begin
            miscompares++;
            $display("FAIL midframe_reset got %h exp %h", obs, RESET_VEC);
        end
        @(posedge clk_vga);
        #1;
        rst_n = 1'b1;
        start_i = 1'b1;
        tick();
        set_px(0, 0, 0, 4'b0000, 0);
        frame_start_i = 1'b1;
        tick();
        vectors++;
        if (game_status_o !== 3'b001 || crash_me_enemy_o !== 4'b0 || obs !== model_vec()) begin
            miscompares++;
            $display("FAIL post_reset_commit got %h exp %h", obs, model_vec());
        end
    endtask

    initial begin
        frame_start_i = 1'b0; start_i = 1'b0; pause_i = 1'b0; bomb_req_i = 1'b0;
        set_px(0, 0, 0, 4'b0000, 0);
        test_reset();
        test_start();
        test_bullet_hits();
        test_invuln();
        test_over_pause();
        test_bomb();
        test_pause_freeze();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
